// File: rtl/data_path_mc.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB datapath. Control signals come from an
// external decoder that watches instr_out; this block only sequences and computes.
module data_path_mc #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            write_ctrl,
    input  logic            operand_ctrl,
    input  logic            load_ctrl,
    input  logic            store_ctrl,
    input  logic            branch_flag,
    input  logic [3:0]      ctrl_op,
    output logic [31:0]     instr_out,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ready,
    input  logic [31:0]     imem_rdata,
    output logic            dmem_req,
    output logic            dmem_we,
    output logic [XLEN-1:0] dmem_addr,
    output logic [XLEN-1:0] dmem_wdata,
    input  logic            dmem_ready,
    input  logic [XLEN-1:0] dmem_rdata,
    output logic            retire,
    output logic [XLEN-1:0] pc_out
);
    localparam int SHW = $clog2(XLEN);

    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;

    logic [2:0]        state;
    logic [XLEN-1:0]   pc, imm, alu_res, load_data;
    logic [4:0]        rs1, rs2, rd;
    logic [XLEN-1:0]   regs [32];
    logic [XLEN-1:0]   rs1_val, rs2_val, op_b, alu_out, imm_dec;
    logic signed [31:0] imm32;
    logic              taken;
    logic              unused_opcode;

    // Opcode is decoded outside this block.
    assign unused_opcode = ^instr_out[6:0];

    assign rd         = instr_out[11:7];
    assign rs1_val    = (rs1 == 5'd0) ? '0 : regs[rs1];
    assign rs2_val    = (rs2 == 5'd0) ? '0 : regs[rs2];
    assign op_b       = operand_ctrl ? imm : rs2_val;
    assign imem_addr  = pc;
    assign pc_out     = pc;
    assign dmem_addr  = alu_res;
    assign dmem_wdata = rs2_val;

    always_comb begin
        imm32 = {{20{instr_out[31]}}, instr_out[31:20]};
        if (branch_flag)
            imm32 = {{19{instr_out[31]}}, instr_out[31], instr_out[7],
                     instr_out[30:25], instr_out[11:8], 1'b0};
        else if (store_ctrl)
            imm32 = {{20{instr_out[31]}}, instr_out[31:25], instr_out[11:7]};
    end

    assign imm_dec = XLEN'(imm32);

    always_comb begin
        alu_out = '0;
        case (ctrl_op)
            4'b0000: alu_out = rs1_val + op_b;
            4'b0001: alu_out = rs1_val - op_b;
            4'b0010: alu_out = rs1_val & op_b;
            4'b0011: alu_out = rs1_val | op_b;
            4'b0100: alu_out = rs1_val ^ op_b;
            4'b0101: alu_out = rs1_val << op_b[SHW-1:0];
            4'b0110: alu_out = rs1_val >> op_b[SHW-1:0];
            4'b0111: alu_out = $unsigned($signed(rs1_val) >>> op_b[SHW-1:0]);
            4'b1000: alu_out = {{(XLEN-1){1'b0}}, $signed(rs1_val) < $signed(op_b)};
            4'b1001: alu_out = {{(XLEN-1){1'b0}}, rs1_val < op_b};
            default: alu_out = '0;
        endcase
    end

    // Branch compare works on register values, independent of the ALU op.
    always_comb begin
        case (instr_out[14:12])
            3'b000:  taken = (rs1_val == rs2_val);
            3'b001:  taken = (rs1_val != rs2_val);
            3'b100:  taken = ($signed(rs1_val) <  $signed(rs2_val));
            3'b101:  taken = ($signed(rs1_val) >= $signed(rs2_val));
            3'b110:  taken = (rs1_val <  rs2_val);
            3'b111:  taken = (rs1_val >= rs2_val);
            default: taken = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_FETCH;
            pc        <= RESET_PC;
            instr_out <= '0;
            imem_req  <= 1'b0;
            dmem_req  <= 1'b0;
            dmem_we   <= 1'b0;
            retire    <= 1'b0;
            rs1       <= '0;
            rs2       <= '0;
            imm       <= '0;
            alu_res   <= '0;
            load_data <= '0;
        end else begin
            retire <= 1'b0;
            case (state)
                S_FETCH: begin
                    // After reset the request is raised on the first edge.
                    if (!imem_req) begin
                        imem_req <= 1'b1;
                    end else if (imem_ready) begin
                        instr_out <= imem_rdata;
                        imem_req  <= 1'b0;
                        state     <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    rs1   <= instr_out[19:15];
                    rs2   <= instr_out[24:20];
                    imm   <= imm_dec;
                    state <= S_EXEC;
                end
                S_EXEC: begin
                    alu_res <= alu_out;
                    if (load_ctrl || store_ctrl) begin
                        dmem_req <= 1'b1;
                        dmem_we  <= store_ctrl;
                        state    <= S_MEM;
                    end else begin
                        retire <= 1'b1;
                        state  <= S_WB;
                    end
                end
                S_MEM: begin
                    if (dmem_req && dmem_ready) begin
                        load_data <= dmem_rdata;
                        dmem_req  <= 1'b0;
                        dmem_we   <= 1'b0;
                        retire    <= 1'b1;
                        state     <= S_WB;
                    end
                end
                S_WB: begin
                    pc       <= (branch_flag && taken) ? pc + imm : pc + XLEN'(4);
                    imem_req <= 1'b1;
                    state    <= S_FETCH;
                end
                default: state <= S_FETCH;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (state == S_WB && write_ctrl && rd != 5'd0)
            regs[rd] <= load_ctrl ? load_data : alu_res;
    end
endmodule

// File: tb/tb_data_path_mc.sv
// Bench for data_path_mc: acts as decoder, imem and dmem; checks against an
// instruction-level model of registers, memory and PC.
module tb_data_path_mc;
    localparam logic [31:0] RST_PC = 32'h100;

    logic        clk = 1'b0, reset_n = 1'b0;
    logic        write_ctrl = 1'b0, operand_ctrl = 1'b0, load_ctrl = 1'b0;
    logic        store_ctrl = 1'b0, branch_flag = 1'b0;
    logic [3:0]  ctrl_op = 4'd0;
    logic [31:0] instr_out, imem_addr, dmem_addr, dmem_wdata, pc_out;
    logic [31:0] imem_rdata = '0, dmem_rdata = '0;
    logic        imem_req, dmem_req, dmem_we, retire;
    logic        imem_ready = 1'b0, dmem_ready = 1'b0;

    int n_cmp = 0, n_err = 0;

    typedef struct packed {
        logic [31:0] word;
        logic wr, opb, ld, st, br;
        logic [3:0] op;
    } ins_t;

    logic [31:0] m_reg [32];
    logic [31:0] m_pc;
    logic [31:0] m_mem [logic [31:0]];

    data_path_mc #(.XLEN(32), .RESET_PC(RST_PC)) dut (
        .clk(clk), .reset_n(reset_n),
        .write_ctrl(write_ctrl), .operand_ctrl(operand_ctrl), .load_ctrl(load_ctrl),
        .store_ctrl(store_ctrl), .branch_flag(branch_flag), .ctrl_op(ctrl_op),
        .instr_out(instr_out),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready), .imem_rdata(imem_rdata),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
        .retire(retire), .pc_out(pc_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1, input logic [4:0] rd);
        return {imm, rs1, 3'b000, rd, 7'b0010011};
    endfunction
    function automatic logic [31:0] enc_r(input logic [4:0] rs2, input logic [4:0] rs1, input logic [4:0] rd);
        return {7'b0, rs2, rs1, 3'b000, rd, 7'b0110011};
    endfunction
    function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2, input logic [4:0] rs1);
        return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
    endfunction
    function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2, input logic [4:0] rs1, input logic [2:0] f3);
        return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
    endfunction
    function automatic ins_t mk(input logic [31:0] w, input logic wr, input logic opb, input logic ld,
                                input logic st, input logic br, input logic [3:0] op);
        ins_t t;
        t.word = w; t.wr = wr; t.opb = opb; t.ld = ld; t.st = st; t.br = br; t.op = op;
        return t;
    endfunction
    function automatic ins_t addi(input logic [4:0] rd, input logic [4:0] rs1, input logic [11:0] imm);
        return mk(enc_i(imm, rs1, rd), 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
    endfunction
    function automatic ins_t sw(input logic [4:0] rs2, input logic [11:0] off);
        return mk(enc_s(off, rs2, 5'd0), 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'd0);
    endfunction
    function automatic ins_t br(input logic [2:0] f3, input logic [4:0] rs1, input logic [4:0] rs2, input logic [12:0] imm);
        return mk(enc_b(imm, rs2, rs1, f3), 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0);
    endfunction

    // Runs one instruction starting at a negedge in FETCH; ends at the negedge after retire.
    task automatic exec(input ins_t in, input int iwait, input int dwait, input bit abort);
        logic [31:0] w, imm, a, b2, bv, res, ld, nxt;
        logic [4:0]  rs1, rs2, rd;
        logic [2:0]  f3;
        int sh, cyc, dcnt, exp_lat;
        bit tk, mem, done, acked;
        w = in.word; rs1 = w[19:15]; rs2 = w[24:20]; rd = w[11:7]; f3 = w[14:12];
        if (in.br)      imm = {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
        else if (in.st) imm = {{20{w[31]}}, w[31:25], w[11:7]};
        else            imm = {{20{w[31]}}, w[31:20]};
        a = m_reg[rs1]; b2 = m_reg[rs2]; bv = in.opb ? imm : b2;
        sh = int'(bv % 32);
        case (in.op)
            4'd0: res = a + bv;
            4'd1: res = a - bv;
            4'd2: res = a & bv;
            4'd3: res = a | bv;
            4'd4: res = a ^ bv;
            4'd5: res = a << sh;
            4'd6: res = a >> sh;
            4'd7: res = $unsigned($signed(a) >>> sh);
            4'd8: res = ($signed(a) < $signed(bv)) ? 32'd1 : 32'd0;
            4'd9: res = (a < bv) ? 32'd1 : 32'd0;
            default: res = 32'd0;
        endcase
        case (f3)
            3'b000: tk = (a == b2);
            3'b001: tk = (a != b2);
            3'b100: tk = ($signed(a) < $signed(b2));
            3'b101: tk = ($signed(a) >= $signed(b2));
            3'b110: tk = (a < b2);
            3'b111: tk = (a >= b2);
            default: tk = 1'b0;
        endcase
        nxt = (in.br && tk) ? m_pc + imm : m_pc + 32'd4;
        mem = in.ld | in.st;
        exp_lat = mem ? 5 + dwait : 4;
        ld = '0;
        if (in.ld) begin
            if (m_mem.exists(res)) ld = m_mem[res];
            else begin ld = $urandom; m_mem[res] = ld; end
        end

        chk("fetch_req", {31'd0, imem_req}, 32'd1);
        chk("fetch_addr", imem_addr, m_pc);
        for (int i = 0; i < iwait; i++) begin
            imem_ready = 1'b0;
            @(negedge clk);
            chk("fetch_hold", {31'd0, imem_req}, 32'd1);
        end
        imem_rdata = w; imem_ready = 1'b1;
        write_ctrl = in.wr; operand_ctrl = in.opb; load_ctrl = in.ld;
        store_ctrl = in.st; branch_flag = in.br; ctrl_op = in.op;
        cyc = 1; dcnt = 0; done = 0; acked = 0;
        while (!done && cyc < 40) begin
            @(negedge clk);
            cyc++;
            imem_ready = 1'($urandom_range(0, 1)); imem_rdata = $urandom;
            dmem_ready = 1'b0; dmem_rdata = $urandom;
            chk("req_excl", {31'd0, imem_req & dmem_req}, 32'd0);
            if (cyc == 2) chk("instr_out", instr_out, w);
            if (retire) begin
                done = 1;
            end else if (dmem_req) begin
                if (acked) chk("dmem_req_drop", {31'd0, dmem_req}, 32'd0);
                if (dcnt == 0) begin
                    chk("dmem_addr", dmem_addr, res);
                    chk("dmem_we", {31'd0, dmem_we}, {31'd0, in.st});
                    if (in.st) chk("dmem_wdata", dmem_wdata, b2);
                    if (abort) begin
                        reset_n = 1'b0;
                        #1;
                        chk("abort_dmem_req", {31'd0, dmem_req}, 32'd0);
                        chk("abort_dmem_we", {31'd0, dmem_we}, 32'd0);
                        chk("abort_pc", pc_out, RST_PC);
                        imem_ready = 1'b0;
                        return;
                    end
                end
                if (dcnt < dwait) dcnt++;
                else begin dmem_ready = 1'b1; dmem_rdata = ld; acked = 1; end
            end else begin
                dmem_ready = 1'($urandom_range(0, 1));
            end
        end
        imem_ready = 1'b0; dmem_ready = 1'b0;
        chk(done ? "latency" : "timeout", cyc, exp_lat);
        chk("instr_hold", instr_out, w);
        if (in.st) m_mem[res] = b2;
        if (in.wr && rd != 5'd0) m_reg[rd] = in.ld ? ld : res;
        m_pc = nxt;
        @(negedge clk);
        chk("retire_pulse", {31'd0, retire}, 32'd0);
        chk("pc_out", pc_out, m_pc);
    endtask

    initial begin
        ins_t r;
        int kind;
        for (int i = 0; i < 32; i++) m_reg[i] = '0;
        repeat (3) @(negedge clk);
        chk("rst_imem_req", {31'd0, imem_req}, 32'd0);
        chk("rst_dmem_req", {31'd0, dmem_req}, 32'd0);
        chk("rst_dmem_we", {31'd0, dmem_we}, 32'd0);
        chk("rst_retire", {31'd0, retire}, 32'd0);
        chk("rst_instr", instr_out, 32'd0);
        chk("rst_pc", pc_out, RST_PC);
        #3 reset_n = 1'b1;
        @(negedge clk);
        m_pc = RST_PC;

        exec(addi(5'd1, 5'd0, 12'hFFB), 10, 0, 0);
        exec(mk(enc_r(5'd1, 5'd0, 5'd2), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd1), 0, 0, 0);
        exec(sw(5'd1, 12'h40), 0, 0, 0);
        exec(sw(5'd2, 12'd8), 0, 3, 0);
        exec(mk(enc_i(12'd8, 5'd0, 5'd3), 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0), 0, 3, 0);
        exec(sw(5'd3, 12'h44), 0, 0, 0);

        for (int i = 4; i < 32; i++) exec(addi(5'(i), 5'd0, 12'($urandom)), 0, 0, 0);

        exec(addi(5'd4, 5'd0, 12'd7), 0, 0, 0);
        exec(addi(5'd5, 5'd0, 12'd7), 0, 0, 0);
        exec(addi(5'd6, 5'd0, 12'd1), 0, 0, 0);
        exec(addi(5'd7, 5'd0, 12'hFFF), 0, 0, 0);
        exec(br(3'b000, 5'd0, 5'd0, 13'(32'h20 - m_pc)), 0, 0, 0);
        chk("jump_pc", pc_out, 32'h20);
        exec(br(3'b101, 5'd4, 5'd5, 13'h1FF8), 0, 0, 0);
        chk("bge_pc", pc_out, 32'h18);
        exec(br(3'b110, 5'd6, 5'd7, 13'd16), 0, 0, 0);
        chk("bltu_pc", pc_out, 32'h28);
        exec(br(3'b010, 5'd4, 5'd5, 13'd64), 0, 0, 0);
        chk("f3_010_pc", pc_out, 32'h2C);

        exec(addi(5'd0, 5'd0, 12'd9), 0, 0, 0);
        exec(sw(5'd0, 12'h48), 0, 0, 0);
        exec(addi(5'd8, 5'd0, 12'd33), 0, 0, 0);
        exec(addi(5'd9, 5'd0, 12'd3), 0, 0, 0);
        exec(mk(enc_r(5'd8, 5'd9, 5'd10), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd5), 0, 0, 0);
        exec(sw(5'd10, 12'h4C), 0, 0, 0);

        for (int n = 0; n < 250; n++) begin
            kind = $urandom_range(0, 4);
            r = mk($urandom, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'($urandom_range(0, 15)));
            case (kind)
                0: r.opb = 1'b1;
                1: r.wr = 1'($urandom_range(0, 1));
                2: begin r.ld = 1'b1; r.opb = 1'b1; r.op = 4'd0; end
                3: begin r.st = 1'b1; r.opb = 1'b1; r.op = 4'd0; r.wr = 1'b0; end
                default: begin r.br = 1'b1; r.wr = 1'b0; end
            endcase
            exec(r, $urandom_range(0, 2), $urandom_range(0, 3), 0);
        end

        exec(sw(5'd9, 12'h50), 0, 2, 1);
        @(negedge clk);
        #3 reset_n = 1'b1;
        @(negedge clk);
        m_pc = RST_PC;
        exec(sw(5'd10, 12'h54), 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/data_path_mc.md
DATA_PATH_MC -- requirements
Module: data_path_mc

Interface
REQ-001 SHALL have parameter XLEN, default 32, register/ALU/address width; legal values 32 and 64.
REQ-002 SHALL have parameter RESET_PC, default 0, PC value loaded at reset.
REQ-003 SHALL have port clk, input, 1, single clock; all state updates on the rising edge.
REQ-004 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have control inputs write_ctrl, operand_ctrl, load_ctrl, store_ctrl and branch_flag, each input, 1; all come from the external decoder and are valid while instr_out is stable.
REQ-006 SHALL have port ctrl_op, input, 4, ALU operation select.
REQ-007 SHALL have port instr_out, output, 32, latched instruction driven to the external decoder.
REQ-008 SHALL have instruction-memory ports: imem_req out 1; imem_addr out XLEN; imem_ready in 1; imem_rdata in 32.
REQ-009 SHALL have data-memory ports: dmem_req out 1; dmem_we out 1; dmem_addr out XLEN; dmem_wdata out XLEN; dmem_ready in 1; dmem_rdata in XLEN.
REQ-010 SHALL have port retire, output, 1, one-cycle pulse per completed instruction.
REQ-011 SHALL have port pc_out, output, XLEN, current PC.

Function
REQ-012 SHALL implement a multi-cycle FSM with states FETCH, DECODE, EXEC, MEM and WB.
REQ-013 FETCH: SHALL hold imem_req=1 and imem_addr=PC; on imem_ready=1, latch imem_rdata into instr_out and go to DECODE; with imem_ready=0, SHALL stay in FETCH indefinitely.
REQ-014 DECODE: SHALL latch rs1 = instr[19:15], rs2 = instr[24:20], and the immediate into internal registers; next state is EXEC.
REQ-015 Immediate SHALL be I-type by default, S-type when store_ctrl=1 and B-type when branch_flag=1, sign-extended to XLEN.
REQ-016 EXEC: ALU operand B SHALL be imm when operand_ctrl=1, else rs2; the ALU result SHALL be latched.
REQ-017 EXEC next state SHALL be MEM when load_ctrl or store_ctrl is 1, else WB.
REQ-018 ALU encoding SHALL be:
  - 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR
  - 0101 SLL, 0110 SRL, 0111 SRA, using shift amount B[log2(XLEN)-1:0]
  - 1000 SLT (signed), 1001 SLTU
  - all other codes SHALL produce 0; all arithmetic SHALL wrap modulo 2^XLEN.
REQ-019 MEM: SHALL hold dmem_req=1, dmem_addr=ALU result, dmem_we=store_ctrl and dmem_wdata=rs2 until dmem_ready=1; load data SHALL be latched on dmem_ready; next state is WB.
REQ-020 WB: when write_ctrl=1 and rd (instr[11:7]) is not 0, register rd SHALL be written with the load data if load_ctrl=1, else with the ALU result.
REQ-021 Register file SHALL be 32 x XLEN; x0 SHALL always read 0 and writes to x0 SHALL be ignored.
REQ-022 Branch conditions (funct3 = instr[14:12]) SHALL be evaluated from rs1/rs2 directly, not from ALU flags:
  - 000 EQ, 001 NE, 100 LT signed, 101 GE signed (equality taken), 110 LTU, 111 GEU
  - funct3 010 and 011 SHALL never be taken.
REQ-023 WB: PC SHALL become PC+imm when branch_flag=1 and the condition holds, else PC+4; retire SHALL pulse for one cycle; next state is FETCH.
REQ-024 dmem_req and imem_req SHALL never both be 1 in the same cycle.
REQ-025 Minimum latency SHALL be 4 cycles for a non-memory instruction and 5 cycles for a load or store, with zero wait states.
REQ-026 A ready input asserted while the matching req is 0 SHALL be ignored.

Reset
REQ-027 reset_n=0 SHALL asynchronously force state=FETCH, PC=RESET_PC, instr_out=0, imem_req=0, dmem_req=0, dmem_we=0 and retire=0.
REQ-028 Register-file contents SHALL NOT be reset; all other datapath latches SHALL reset to 0.
REQ-029 Reset asserted mid-transaction SHALL abort it; the first request after reset_n rises SHALL be a fetch at RESET_PC, issued on the first clock edge.

Verification
REQ-030 Reset with RESET_PC=0x100, then release -> imem_req=1 with imem_addr=0x100; hold imem_ready=0 for 10 cycles -> FSM stays in FETCH and imem_req stays 1.
REQ-031 ADDI x1,x0,-5 then SUB x2,x0,x1, zero wait states -> x1=0xFFFFFFFB, x2=5, retire pulses at cycles 4 and 8.
REQ-032 SW x2,8(x0) then LW x3,8(x0), dmem_ready delayed by 3 cycles -> dmem_we=1, addr 8, wdata 5 for the store; x3=5; each instruction takes 8 cycles.
REQ-033 BGE with rs1=rs2=7 and imm=-8 at PC 0x20 -> next PC 0x18; BLTU with rs1=1, rs2=0xFFFFFFFF -> taken; funct3 010 -> PC+4.
REQ-034 ADDI x0,x0,9 -> x0 still reads 0; SLL with shift amount 33 at XLEN=32 -> shifts by 1.
REQ-035 Assert reset_n=0 during MEM of a store -> dmem_req drops immediately (asynchronously); after release, fetch at RESET_PC.
